// File: rtl/piano_pkg.sv
// Shared piano definitions: song entry layout, sequencer FSM states and
// the note-to-LED mapping also used by the controller.
package piano_pkg;

  localparam int NOTE_W = 4;
  localparam int OCT_W  = 2;
  localparam int KEY_W  = 7;
  localparam int HDR_W  = NOTE_W + OCT_W;

  // Entry = {octave, note, dur}; offsets are measured above the dur field.
  localparam int NOTE_OFS = 0;
  localparam int OCT_OFS  = NOTE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_WAIT_KEY
  } state_t;

  function automatic logic [KEY_W-1:0] note_to_led(input logic [NOTE_W-1:0] note);
    logic [KEY_W-1:0] led;
    led = '0;
    case (note)
      4'd1:    led = 7'b0000001;
      4'd2:    led = 7'b0000010;
      4'd3:    led = 7'b0000100;
      4'd4:    led = 7'b0001000;
      4'd5:    led = 7'b0010000;
      4'd6:    led = 7'b0100000;
      4'd7:    led = 7'b1000000;
      default: led = '0;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/song_ram.sv
// Single-port song store: synchronous write, synchronous registered read.
module song_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/piano_sequencer.sv
// Auto-play / learn sequencer stepping through RAM-held songs.
// Learn mode (WAIT_KEY, miss_cnt) is built only with PIANO_SEQ_LEARN_EN.
module piano_sequencer
  import piano_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int SONG_DEPTH     = 32,
  parameter int DUR_W          = 4,
  parameter int TICKS_PER_UNIT = 25_000_000,
  parameter int GAP_CYCLES     = 2_500_000
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    stop,
  input  logic                                    next_song,
  input  logic                                    prev_song,
  input  logic                                    loop_en,
  input  logic                                    learn,
  input  logic [KEY_W-1:0]                        keys,
  input  logic                                    wr_en,
  input  logic [$clog2(NUM_SONGS*SONG_DEPTH)-1:0] wr_addr,
  input  logic [HDR_W+DUR_W-1:0]                  wr_data,
  output logic [NOTE_W-1:0]                       note_out,
  output logic [OCT_W-1:0]                        octave_out,
  output logic [KEY_W-1:0]                        led_out,
  output logic [$clog2(NUM_SONGS)-1:0]            song_idx,
  output logic [$clog2(SONG_DEPTH)-1:0]           step_idx,
  output logic                                    busy,
  output logic                                    done
`ifdef PIANO_SEQ_LEARN_EN
  ,
  output logic [7:0]                              miss_cnt
`endif
);

  localparam int SONG_W  = $clog2(NUM_SONGS);
  localparam int STEP_W  = $clog2(SONG_DEPTH);
  localparam int ADDR_W  = SONG_W + STEP_W;
  localparam int ENTRY_W = HDR_W + DUR_W;
  localparam int TW      = DUR_W + $clog2(TICKS_PER_UNIT) + 1;
  localparam int GW      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t              r_state;
  logic                r_fetch_ph;
  logic [SONG_W-1:0]   r_song;
  logic [STEP_W-1:0]   r_step;
  logic [NOTE_W-1:0]   r_note;
  logic [OCT_W-1:0]    r_oct;
  logic [KEY_W-1:0]    r_led;
  logic                r_done;
  logic [TW-1:0]       r_tick;
  logic [GW-1:0]       r_gap;

  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [ENTRY_W-1:0]  w_rdata;
  logic [DUR_W-1:0]    w_dur;
  logic [NOTE_W-1:0]   w_note;
  logic [OCT_W-1:0]    w_oct;
  logic [KEY_W-1:0]    w_note_led;
  logic                w_nxt;
  logic                w_prv;
  logic                w_abort;
  logic                w_start;
  logic                w_adv_done;
  state_t              w_adv_state;

  assign w_we   = wr_en && (r_state == S_IDLE);
  assign w_addr = w_we ? wr_addr : {r_song, r_step};

  song_ram #(
    .DEPTH (NUM_SONGS*SONG_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_song_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (wr_data),
    .o_rdata (w_rdata)
  );

  assign w_dur      = w_rdata[DUR_W-1:0];
  assign w_note     = w_rdata[DUR_W+NOTE_OFS +: NOTE_W];
  assign w_oct      = w_rdata[DUR_W+OCT_OFS +: OCT_W];
  assign w_note_led = note_to_led(w_note);

  // Opposing song pulses cancel; a valid song change aborts play and masks start.
  assign w_nxt   = next_song & ~prev_song;
  assign w_prv   = prev_song & ~next_song;
  assign w_abort = stop | ((w_nxt | w_prv) & (r_state != S_IDLE));
  assign w_start = start & ~stop & ~next_song & ~prev_song & (r_state == S_IDLE);

  // Step advance: the step counter wraps to 0 at the last entry on its own.
  assign w_adv_done  = (r_step == STEP_W'(SONG_DEPTH-1)) && !loop_en;
  assign w_adv_state = w_adv_done ? S_IDLE : S_FETCH;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_ph <= 1'b0;
      r_song     <= '0;
      r_step     <= '0;
      r_note     <= '0;
      r_oct      <= '0;
      r_led      <= '0;
      r_done     <= 1'b0;
      r_tick     <= '0;
      r_gap      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_nxt)      r_song <= r_song + 1'b1;
      else if (w_prv) r_song <= r_song - 1'b1;

      if (w_abort) begin
        r_state    <= S_IDLE;
        r_fetch_ph <= 1'b0;
        r_step     <= '0;
        r_note     <= '0;
        r_oct      <= '0;
        r_led      <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_state    <= S_FETCH;
              r_fetch_ph <= 1'b0;
              r_step     <= '0;
            end
          end
          S_FETCH: begin
            if (!r_fetch_ph) begin
              r_fetch_ph <= 1'b1;
            end else begin
              r_fetch_ph <= 1'b0;
              if (w_dur == '0) begin
                r_step  <= '0;
                r_state <= loop_en ? S_FETCH : S_IDLE;
                r_done  <= !loop_en;
`ifdef PIANO_SEQ_LEARN_EN
              end else if (learn && (w_note_led != '0)) begin
                r_state <= S_WAIT_KEY;
                r_note  <= w_note;
                r_oct   <= w_oct;
                r_led   <= w_note_led;
`endif
              end else begin
                r_state <= S_PLAY;
                r_tick  <= TW'(w_dur) * TW'(TICKS_PER_UNIT);
                r_note  <= w_note;
                r_oct   <= w_oct;
                r_led   <= w_note_led;
              end
            end
          end
          S_PLAY: begin
            if (r_tick == TW'(1)) begin
              r_note <= '0;
              r_oct  <= '0;
              r_led  <= '0;
              if (GAP_CYCLES == 0) begin
                r_step  <= r_step + 1'b1;
                r_state <= w_adv_state;
                r_done  <= w_adv_done;
              end else begin
                r_state <= S_GAP;
                r_gap   <= GW'(GAP_CYCLES);
              end
            end else begin
              r_tick <= r_tick - 1'b1;
            end
          end
          S_GAP: begin
            if (r_gap == GW'(1)) begin
              r_step  <= r_step + 1'b1;
              r_state <= w_adv_state;
              r_done  <= w_adv_done;
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
`ifdef PIANO_SEQ_LEARN_EN
          S_WAIT_KEY: begin
            if (keys == r_led) begin
              r_note <= '0;
              r_oct  <= '0;
              r_led  <= '0;
              if (GAP_CYCLES == 0) begin
                r_step  <= r_step + 1'b1;
                r_state <= w_adv_state;
                r_done  <= w_adv_done;
              end else begin
                r_state <= S_GAP;
                r_gap   <= GW'(GAP_CYCLES);
              end
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef PIANO_SEQ_LEARN_EN
  logic [7:0]       r_miss;
  logic [KEY_W-1:0] r_keys_prev;

  // A miss is a fresh press (from no key) of anything but the target key.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_miss      <= '0;
      r_keys_prev <= '0;
    end else begin
      r_keys_prev <= keys;
      if (w_start) begin
        r_miss <= '0;
      end else if ((r_state == S_WAIT_KEY) && (r_keys_prev == '0) && (keys != '0) &&
                   (keys != r_led) && (r_miss != 8'hFF)) begin
        r_miss <= r_miss + 8'd1;
      end
    end
  end

  assign miss_cnt = r_miss;
`else
  logic w_unused;
  assign w_unused = ^{learn, keys};
`endif

  assign note_out   = r_note;
  assign octave_out = r_oct;
  assign led_out    = r_led;
  assign song_idx   = r_song;
  assign step_idx   = r_step;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule

// File: doc/piano_sequencer.md
Name: piano_sequencer

Overview:
Parametrised auto-play and learn engine for the piano. It holds NUM_SONGS songs of SONG_DEPTH entries in an internal RAM, which is loaded through a write port. It steps through the selected song and drives note/octave to the buzzer and the target key to the LEDs. It replaces the fixed-song auto path in the controller, and its song index feeds the segment display.

Parameters:
NUM_SONGS, 4, number of song slots; power of two, at least 2.
SONG_DEPTH, 32, entries per song; power of two, at least 4.
DUR_W, 4, width of the duration field in time units.
TICKS_PER_UNIT, 25_000_000, clk cycles per duration unit; at least 1.
GAP_CYCLES, 2_500_000, silent cycles between notes; 0 means no gap.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
start  in  1  one-cycle pulse; begin playing the selected song from step 0
stop  in  1  one-cycle pulse; abort playback
next_song  in  1  one-cycle pulse; song_idx+1, wrapping
prev_song  in  1  one-cycle pulse; song_idx-1, wrapping
loop_en  in  1  level; restart the song at its end
learn  in  1  level; learn mode (see Optional Feature)
keys  in  7  debounced piano keys, one-hot
wr_en  in  1  RAM write strobe
wr_addr  in  log2(NUM_SONGS*SONG_DEPTH)  write address = {song, step}
wr_data  in  6+DUR_W  entry = {octave[1:0], note[3:0], dur[DUR_W-1:0]}
note_out  out  4  note to buzzer; 0 = silent
octave_out  out  2  octave to buzzer
led_out  out  7  one-hot target key: note k in 1..7 sets bit k-1; otherwise 0
song_idx  out  log2(NUM_SONGS)  selected song
step_idx  out  log2(SONG_DEPTH)  current entry
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse at a non-looping song end
miss_cnt  out  8  wrong-key count; present only with the macro

Behaviour:
- Reset (reset==0 at posedge): state IDLE; song_idx, step_idx, note_out, octave_out, led_out, busy, done and miss_cnt all 0. RAM contents are preserved.
- States: IDLE, FETCH, PLAY, GAP, WAIT_KEY.
- RAM reads are synchronous. FETCH lasts exactly 2 cycles: cycle 1 presents {song_idx, step_idx}; cycle 2 registers the entry.
- IDLE + start -> FETCH, with step_idx=0.
- FETCH end, dur==0 (end marker): treat as song end.
- FETCH end, note in 1..7 with learn=1 and the macro enabled: go to WAIT_KEY.
- FETCH end, otherwise: go to PLAY and load the tick counter with dur*TICKS_PER_UNIT.
- PLAY: note_out, octave_out and led_out are driven from the registered entry on the first PLAY cycle. PLAY lasts exactly dur*TICKS_PER_UNIT cycles, then goes to GAP, or skips GAP if GAP_CYCLES==0.
- GAP: note_out=0 and led_out=0 for GAP_CYCLES cycles. Then the step advances.
- Step advance: if step_idx==SONG_DEPTH-1, treat as song end; else step_idx+1 and go to FETCH.
- Song end with loop_en=1: step_idx=0, go to FETCH.
- Song end with loop_en=0: done=1 for 1 cycle, go to IDLE, step_idx=0.
- stop in any state: go to IDLE next cycle, outputs 0. done is not pulsed.
- next_song/prev_song in any state: update song_idx modulo NUM_SONGS; if not IDLE, abort to IDLE as for stop.
- Simultaneous pulses:
  - stop outranks start.
  - next_song and prev_song in the same cycle are both ignored.
  - start together with next_song or prev_song: the song change wins and start is ignored.
- Writes: accepted only in IDLE; wr_en outside IDLE is dropped.
- start while not IDLE: ignored.
- The duration product is computed at width DUR_W+log2(TICKS_PER_UNIT)+1 so it cannot overflow.

Optional Feature:
Macro: PIANO_SEQ_LEARN_EN.
- Defined:
  - WAIT_KEY drives note_out, octave_out and led_out with the target note and holds until keys equals led_out exactly. It then goes to GAP (or directly to step advance if GAP_CYCLES==0).
  - miss_cnt increments, saturating at 255, on each cycle where keys changes from 0 to a nonzero value not equal to led_out.
  - miss_cnt clears on start.
  - Rest entries (note 0 or note above 7) play timed as normal.
- Undefined: the learn input is ignored, WAIT_KEY is unreachable, and the miss_cnt port is absent.

Decomposition:
- Package piano_pkg holds:
  - the entry field widths and slice positions;
  - the state enum;
  - the note-to-one-hot LED function, shared with the controller.
- Sub-module song_ram: single-port sync-write, sync-read RAM of NUM_SONGS*SONG_DEPTH entries, each 6+DUR_W bits wide.

Test Plan:
All scenarios use TICKS_PER_UNIT=4, GAP_CYCLES=2, NUM_SONGS=4, SONG_DEPTH=8.
1. Load song 0 with {1,note 3,dur 2}, {0,note 5,dur 1}, then dur 0; pulse start -> FETCH 2 cycles, note 3 / octave 1 / led_out=0000100 for 8 cycles, 2 silent gap cycles, note 5 for 4 cycles, 2 gap cycles, then done pulses once, busy falls, step_idx=0.
2. Same song with loop_en=1 -> after the second note, step_idx returns to 0 and note 3 replays; no done pulse; stop -> note_out=0 and busy=0 on the next cycle.
3. song_idx=3 plus next_song -> 0; song_idx=0 plus prev_song -> 3; next_song and prev_song together -> unchanged; next_song during PLAY -> IDLE, song_idx incremented.
4. Song 1 with all 8 entries dur=1 and no end marker -> plays all 8 entries, then done; a wr_en issued during playback leaves the RAM unchanged when read back afterwards.
5. reset=0 during PLAY for 1 cycle -> all outputs 0 and IDLE; start -> the same song replays from step 0 (RAM retained).
6. Macro enabled, learn=1, entry note 2 -> holds in WAIT_KEY; keys=0000100 then keys=0 gives miss_cnt=1; keys=0000010 advances to GAP.
